ex_operand_fwd_mux: RTL and testbench
=====================================

Name: ex_operand_fwd_mux

Overview:
- Parametrised successor to the execute-stage 2-to-1 operand mux.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, selects PC/immediate alternates, and registers both ALU operands into the EX stage.
- Provides a valid bit, stall (hold) and flush (bubble).
- Sits between the ID/EX boundary and the ALU.

Parameters:
DATA_WIDTH, 32, width of operands, results, PC and immediate
REG_ADDR_WIDTH, 5, width of register-file addresses (x0 = all zeros)

Ports:
clk  in  1  pipeline clock, rising-edge active
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold all output registers
flush  in  1  insert bubble into EX
id_valid  in  1  ID-stage instruction is valid
id_rs1_addr  in  REG_ADDR_WIDTH  source register 1 address
id_rs2_addr  in  REG_ADDR_WIDTH  source register 2 address
id_rs1_data  in  DATA_WIDTH  register-file read data 1
id_rs2_data  in  DATA_WIDTH  register-file read data 2
id_pc  in  DATA_WIDTH  instruction PC
id_imm  in  DATA_WIDTH  sign-extended immediate
id_alu_src_a  in  1  1 = operand A is PC, 0 = forwarded rs1
id_alu_src_b  in  1  1 = operand B is immediate, 0 = forwarded rs2
exmem_valid  in  1  EX/MEM stage holds a valid instruction
exmem_reg_write  in  1  EX/MEM instruction writes rd
exmem_rd_addr  in  REG_ADDR_WIDTH  EX/MEM destination
exmem_result  in  DATA_WIDTH  EX/MEM ALU result
memwb_valid  in  1  MEM/WB stage holds a valid instruction
memwb_reg_write  in  1  MEM/WB instruction writes rd
memwb_rd_addr  in  REG_ADDR_WIDTH  MEM/WB destination
memwb_result  in  DATA_WIDTH  MEM/WB writeback data
ex_valid  out  1  EX operands valid
ex_op_a  out  DATA_WIDTH  registered ALU operand A
ex_op_b  out  DATA_WIDTH  registered ALU operand B
ex_store_data  out  DATA_WIDTH  registered forwarded rs2, used for stores regardless of alu_src_b
ex_fwd_a_sel  out  2  registered forwarding source for rs1 (debug/perf)
ex_fwd_b_sel  out  2  registered forwarding source for rs2

Behaviour:
- Clock and reset are decided: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset (reset_n low, asynchronous): all outputs 0, i.e. ex_valid=0, operands 0, sel=FWD_RF. Outputs stay 0 until the first rising edge after deassertion.
- Forward select, combinational and computed per operand. For operand address `a`:
  - If exmem_valid & exmem_reg_write & exmem_rd_addr==a & a!=0 -> FWD_EXMEM.
  - Else if memwb_valid & memwb_reg_write & memwb_rd_addr==a & a!=0 -> FWD_MEMWB.
  - Else -> FWD_RF.
  - When EX/MEM and MEM/WB both match, EX/MEM wins (youngest producer).
  - x0 is never forwarded; a write to x0 always leaves FWD_RF.
- fwd_rs1/fwd_rs2 = value picked by the select (exmem_result / memwb_result / id_rsN_data).
- Operand selection: op_a = id_alu_src_a ? id_pc : fwd_rs1; op_b = id_alu_src_b ? id_imm : fwd_rs2. Store data is always fwd_rs2.
- Pipeline register on each rising edge, priority flush > stall > load:
  - flush=1: ex_valid<=0, operands/store data/sels <=0.
  - stall=1 (flush=0): every output holds its value. Changing forwarding inputs during a stall has no effect on the outputs.
  - Otherwise: ex_valid<=id_valid; all data and sels loaded from the combinational results.
- Latency: exactly 1 cycle from ID inputs to EX outputs. No combinational input-to-output path.
- id_valid=0 with no stall/flush: ex_valid<=0. Data registers still load, contents don't-care.
- Width rules: no arithmetic, pure selection. Address compare is full REG_ADDR_WIDTH equality.
- Reset asserted mid-stall or mid-flush: reset wins immediately.

Decomposition:
- Package `fwd_pkg`:
  - `fwd_sel_t` 2-bit enum: FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10; 2'b11 is reserved and never produced.
  - Constant REG_ZERO = 0.
- Sub-module `fwd_select`, instantiated twice (rs1, rs2). It is combinational: inputs are the source address, regfile data and both producer-stage fields; outputs are sel and forwarded data.
- The top level holds the operand muxes and the pipeline register.

Test Plan:
1. Reset: drive reset_n=0 mid-cycle with id_valid=1 -> all outputs 0 immediately. After release and one edge with rs1_data=0x11, rs2_data=0x22, no matches -> op_a=0x11, op_b=0x22, sels=00, ex_valid=1.
2. Priority: rs1=5; exmem rd=5 result=0xAAAA0001; memwb rd=5 result=0xBBBB0002 -> op_a=0xAAAA0001, fwd_a_sel=10. Then exmem_reg_write=0 -> op_a=0xBBBB0002, sel=01.
3. x0 and invalid producer: rs2=0, exmem rd=0 reg_write=1 result=0xDEAD -> op_b=rs2_data, sel=00. rs1=7 matching memwb with memwb_valid=0 -> no forward.
4. Alternate sources: alu_src_a=1 pc=0x00000400; alu_src_b=1 imm=0xFFFFFFFC; rs2 forwarded from EX/MEM 0x1234 -> op_a=0x400, op_b=0xFFFFFFFC, ex_store_data=0x1234, fwd_b_sel=10.
5. Stall: load op_a=0x55, then stall=1 for 3 cycles while the inputs change -> outputs stay 0x55/valid=1. Release -> new values captured next edge.
6. Flush vs stall: flush=1 & stall=1 with id_valid=1 -> next edge ex_valid=0 and all data 0. Bubble persists while flush is held.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for EX-stage operand forwarding: forwarding-source encoding and the x0 address.
package fwd_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/ex_operand_fwd_mux_if.sv
// ID/EX operand bundle: ID-stage fields, producer-stage write-back fields, pipeline controls and the registered EX outputs.
interface ex_operand_fwd_mux_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) ();
    import fwd_pkg::*;

    logic                      stall;
    logic                      flush;

    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_pc;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic                      id_alu_src_a;
    logic                      id_alu_src_b;

    logic                      exmem_valid;
    logic                      exmem_reg_write;
    logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr;
    logic [DATA_WIDTH-1:0]     exmem_result;

    logic                      memwb_valid;
    logic                      memwb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr;
    logic [DATA_WIDTH-1:0]     memwb_result;

    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     ex_op_a;
    logic [DATA_WIDTH-1:0]     ex_op_b;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    fwd_sel_t                  ex_fwd_a_sel;
    fwd_sel_t                  ex_fwd_b_sel;

    modport master (
        output stall, flush,
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
        output id_pc, id_imm, id_alu_src_a, id_alu_src_b,
        output exmem_valid, exmem_reg_write, exmem_rd_addr, exmem_result,
        output memwb_valid, memwb_reg_write, memwb_rd_addr, memwb_result,
        input  ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_fwd_a_sel, ex_fwd_b_sel
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
        input  id_pc, id_imm, id_alu_src_a, id_alu_src_b,
        input  exmem_valid, exmem_reg_write, exmem_rd_addr, exmem_result,
        input  memwb_valid, memwb_reg_write, memwb_rd_addr, memwb_result,
        output ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_fwd_a_sel, ex_fwd_b_sel
    );

endinterface

// File: rtl/fwd_select.sv
// Per-operand RAW hazard resolver: picks EX/MEM, MEM/WB or regfile data for one source register.
// Purely combinational (0 cycles); no flow control of its own.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0]     rf_data,
    input  logic                      exmem_valid,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_valid,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output fwd_sel_t                  sel,
    output logic [DATA_WIDTH-1:0]     fwd_data
);

    logic src_nonzero;
    logic exmem_hit;
    logic memwb_hit;

    // x0 is hardwired to zero, so a "write" to it must never be forwarded.
    assign src_nonzero = (src_addr != REG_ADDR_WIDTH'(REG_ZERO));
    assign exmem_hit   = exmem_valid && exmem_reg_write && (exmem_rd_addr == src_addr) && src_nonzero;
    assign memwb_hit   = memwb_valid && memwb_reg_write && (memwb_rd_addr == src_addr) && src_nonzero;

    // EX/MEM is checked first: it holds the youngest producer of the register.
    always_comb begin
        sel      = FWD_RF;
        fwd_data = rf_data;
        if (exmem_hit) begin
            sel      = FWD_EXMEM;
            fwd_data = exmem_result;
        end else if (memwb_hit) begin
            sel      = FWD_MEMWB;
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/ex_operand_fwd_mux.sv
// EX-stage operand register: forwards rs1/rs2, applies PC/immediate alternates, registers operands for the ALU.
// Latency 1 cycle; stall holds every output, flush (dominant) loads a bubble; no combinational in-to-out path.
module ex_operand_fwd_mux
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ex_operand_fwd_mux_if.slave  bus
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] op_a;
        logic [DATA_WIDTH-1:0] op_b;
        logic [DATA_WIDTH-1:0] store_data;
        fwd_sel_t              sel_a;
        fwd_sel_t              sel_b;
    } ex_reg_t;

    fwd_sel_t              rs1_sel;
    fwd_sel_t              rs2_sel;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    ex_reg_t ex_d;
    ex_reg_t ex_q;

    fwd_select #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .src_addr        (bus.id_rs1_addr),
        .rf_data         (bus.id_rs1_data),
        .exmem_valid     (bus.exmem_valid),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd_addr   (bus.exmem_rd_addr),
        .exmem_result    (bus.exmem_result),
        .memwb_valid     (bus.memwb_valid),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd_addr   (bus.memwb_rd_addr),
        .memwb_result    (bus.memwb_result),
        .sel             (rs1_sel),
        .fwd_data        (fwd_rs1)
    );

    fwd_select #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .src_addr        (bus.id_rs2_addr),
        .rf_data         (bus.id_rs2_data),
        .exmem_valid     (bus.exmem_valid),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd_addr   (bus.exmem_rd_addr),
        .exmem_result    (bus.exmem_result),
        .memwb_valid     (bus.memwb_valid),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd_addr   (bus.memwb_rd_addr),
        .memwb_result    (bus.memwb_result),
        .sel             (rs2_sel),
        .fwd_data        (fwd_rs2)
    );

    // Store data always takes forwarded rs2 even when operand B is the immediate.
    always_comb begin
        ex_d            = '0;
        ex_d.valid      = bus.id_valid;
        ex_d.op_a       = bus.id_alu_src_a ? bus.id_pc  : fwd_rs1;
        ex_d.op_b       = bus.id_alu_src_b ? bus.id_imm : fwd_rs2;
        ex_d.store_data = fwd_rs2;
        ex_d.sel_a      = rs1_sel;
        ex_d.sel_b      = rs2_sel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (!bus.stall) begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_op_a       = ex_q.op_a;
    assign bus.ex_op_b       = ex_q.op_b;
    assign bus.ex_store_data = ex_q.store_data;
    assign bus.ex_fwd_a_sel  = ex_q.sel_a;
    assign bus.ex_fwd_b_sel  = ex_q.sel_b;

endmodule

// File: tb/tb_ex_operand_fwd_mux.sv
// Scoreboard bench for ex_operand_fwd_mux: posedge reference model pushes expected EX state, negedge monitor pops and compares.
module tb_ex_operand_fwd_mux;
    import fwd_pkg::*;

    typedef struct {
        logic        vld;
        logic        known;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] sd;
        logic [1:0]  sa;
        logic [1:0]  sb;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t model_st;

    ex_operand_fwd_mux_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    ex_operand_fwd_mux #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t zero_state();
        exp_t z;
        z.vld = 1'b0; z.known = 1'b1;
        z.op_a = '0; z.op_b = '0; z.sd = '0; z.sa = '0; z.sb = '0;
        return z;
    endfunction

    // Producers listed oldest-first; a later matching producer overrides an earlier one.
    function automatic void resolve(input logic [4:0] addr, input logic [31:0] rf,
                                    input logic [1:0] pv, input logic [9:0] prd, input logic [63:0] pres,
                                    output logic [1:0] sel, output logic [31:0] val);
        logic [1:0] codes [2];
        codes[0] = 2'b01;
        codes[1] = 2'b10;
        sel = 2'b00;
        val = rf;
        for (int p = 0; p < 2; p++) begin
            if (pv[p] && addr != 5'd0 && prd[p*5 +: 5] == addr) begin
                sel = codes[p];
                val = pres[p*32 +: 32];
            end
        end
    endfunction

    function automatic exp_t model_load();
        exp_t        e;
        logic [1:0]  pv;
        logic [9:0]  prd;
        logic [63:0] pres;
        logic [31:0] r1;
        logic [31:0] r2;
        pv   = {bus.exmem_valid & bus.exmem_reg_write, bus.memwb_valid & bus.memwb_reg_write};
        prd  = {bus.exmem_rd_addr, bus.memwb_rd_addr};
        pres = {bus.exmem_result, bus.memwb_result};
        resolve(bus.id_rs1_addr, bus.id_rs1_data, pv, prd, pres, e.sa, r1);
        resolve(bus.id_rs2_addr, bus.id_rs2_data, pv, prd, pres, e.sb, r2);
        e.vld   = bus.id_valid;
        e.known = bus.id_valid;
        e.op_a  = bus.id_alu_src_a ? bus.id_pc : r1;
        e.op_b  = bus.id_alu_src_b ? bus.id_imm : r2;
        e.sd    = r2;
        return e;
    endfunction

    // Reference model: evaluates inputs at each rising edge.
    initial begin
        model_st = zero_state();
        forever begin
            @(posedge clk);
            if (!reset_n)         model_st = zero_state();
            else if (bus.flush)   model_st = zero_state();
            else if (!bus.stall)  model_st = model_load();
            sb_q.push_back(model_st);
        end
    end

    // Monitor: compares registered outputs away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ex_valid", {31'b0, bus.ex_valid}, {31'b0, e.vld});
                if (e.known) begin
                    chk("ex_op_a", bus.ex_op_a, e.op_a);
                    chk("ex_op_b", bus.ex_op_b, e.op_b);
                    chk("ex_store_data", bus.ex_store_data, e.sd);
                    chk("ex_fwd_a_sel", {30'b0, bus.ex_fwd_a_sel}, {30'b0, e.sa});
                    chk("ex_fwd_b_sel", {30'b0, bus.ex_fwd_b_sel}, {30'b0, e.sb});
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.stall = 1'b0;        bus.flush = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_rs1_addr = '0;    bus.id_rs2_addr = '0;
        bus.id_rs1_data = '0;    bus.id_rs2_data = '0;
        bus.id_pc = '0;          bus.id_imm = '0;
        bus.id_alu_src_a = 1'b0; bus.id_alu_src_b = 1'b0;
        bus.exmem_valid = 1'b0;  bus.exmem_reg_write = 1'b0;
        bus.exmem_rd_addr = '0;  bus.exmem_result = '0;
        bus.memwb_valid = 1'b0;  bus.memwb_reg_write = 1'b0;
        bus.memwb_rd_addr = '0;  bus.memwb_result = '0;
    endtask

    task automatic rand_id_and_producers();
        bus.id_valid        = ($urandom_range(0, 4) != 0);
        bus.id_rs1_addr     = 5'($urandom_range(0, 7));
        bus.id_rs2_addr     = 5'($urandom_range(0, 7));
        bus.id_rs1_data     = $urandom;
        bus.id_rs2_data     = $urandom;
        bus.id_pc           = $urandom;
        bus.id_imm          = $urandom;
        bus.id_alu_src_a    = ($urandom_range(0, 3) == 0);
        bus.id_alu_src_b    = ($urandom_range(0, 3) == 0);
        bus.exmem_valid     = ($urandom_range(0, 3) != 0);
        bus.exmem_reg_write = ($urandom_range(0, 3) != 0);
        bus.exmem_rd_addr   = 5'($urandom_range(0, 7));
        bus.exmem_result    = $urandom;
        bus.memwb_valid     = ($urandom_range(0, 3) != 0);
        bus.memwb_reg_write = ($urandom_range(0, 3) != 0);
        bus.memwb_rd_addr   = 5'($urandom_range(0, 7));
        bus.memwb_result    = $urandom;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);

        // Release, then a plain load with no producer matches.
        reset_n = 1'b1;
        bus.id_valid = 1'b1;
        bus.id_rs1_addr = 5'd1;  bus.id_rs1_data = 32'h11;
        bus.id_rs2_addr = 5'd2;  bus.id_rs2_data = 32'h22;
        @(negedge clk);

        // Asynchronous reset in mid-cycle with a valid instruction present.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'b0, bus.ex_valid}, 32'd0);
        chk("rst_async_op_a", bus.ex_op_a, 32'd0);
        chk("rst_async_op_b", bus.ex_op_b, 32'd0);
        chk("rst_async_sd", bus.ex_store_data, 32'd0);
        chk("rst_async_sel_a", {30'b0, bus.ex_fwd_a_sel}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Both producers match rs1: EX/MEM wins, then MEM/WB once EX/MEM stops writing.
        bus.id_rs1_addr = 5'd5;
        bus.exmem_valid = 1'b1; bus.exmem_reg_write = 1'b1;
        bus.exmem_rd_addr = 5'd5; bus.exmem_result = 32'hAAAA0001;
        bus.memwb_valid = 1'b1; bus.memwb_reg_write = 1'b1;
        bus.memwb_rd_addr = 5'd5; bus.memwb_result = 32'hBBBB0002;
        @(negedge clk);
        bus.exmem_reg_write = 1'b0;
        @(negedge clk);

        // x0 never forwarded; an invalid producer never forwarded.
        bus.id_rs2_addr = 5'd0; bus.id_rs2_data = 32'h0000_0077;
        bus.exmem_reg_write = 1'b1; bus.exmem_rd_addr = 5'd0; bus.exmem_result = 32'h0000DEAD;
        bus.id_rs1_addr = 5'd7; bus.memwb_rd_addr = 5'd7; bus.memwb_valid = 1'b0;
        @(negedge clk);

        // PC/immediate alternates; store data still carries forwarded rs2.
        bus.id_alu_src_a = 1'b1; bus.id_pc = 32'h0000_0400;
        bus.id_alu_src_b = 1'b1; bus.id_imm = 32'hFFFF_FFFC;
        bus.id_rs2_addr = 5'd3; bus.exmem_rd_addr = 5'd3; bus.exmem_result = 32'h0000_1234;
        @(negedge clk);

        // Stall holds a loaded value while inputs churn.
        idle_inputs();
        bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd4; bus.id_rs1_data = 32'h55;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rand_id_and_producers();
            bus.stall = 1'b1;
            @(negedge clk);
        end
        bus.stall = 1'b0;
        @(negedge clk);

        // Flush dominates stall and keeps inserting bubbles while held.
        rand_id_and_producers();
        bus.id_valid = 1'b1;
        bus.stall = 1'b1; bus.flush = 1'b1;
        repeat (2) @(negedge clk);
        bus.stall = 1'b0; bus.flush = 1'b0;

        for (int i = 0; i < 400; i++) begin
            rand_id_and_producers();
            bus.stall = ($urandom_range(0, 5) == 0);
            bus.flush = ($urandom_range(0, 11) == 0);
            @(negedge clk);
        end

        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
